mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the CPU data port, alongside `data_mem`. Decodes a 16-byte window of the data address space, buffers bytes written by the core in a TX FIFO, and serialises them 8N1 on `tx` with a programmable baud divider. Read data is combinational, matching the single-cycle core's load timing. The SoC data read mux selects `data_o` when `sel` is high.

---
 rtl/mmio_uart_tx_if.sv | 13 +
 rtl/mmio_uart_tx.sv | 232 +++++++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmio_uart_tx_if.sv
// Data-port bus bundle between the CPU core and the memory-mapped UART transmitter.
// The master is the core (or testbench); the slave is mmio_uart_tx.
interface mmio_uart_tx_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        sel;

  modport master (output ce, we, addr, data_i, input data_o, sel);
  modport slave  (input ce, we, addr, data_i, output data_o, sel);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter: 16-byte register window on the CPU data port,
// TX FIFO of FIFO_DEPTH bytes, programmable baud divider, 8N1 serial output.
// Optional build macro MMIO_UART_TX_PARITY_EN adds an even-parity bit (8E1).
// Register map: 0x0 TXDATA (wo push), 0x4 STATUS, 0x8 DIV, 0xC CTRL.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd16
) (
  input  logic              clk,
  input  logic              rst,
  mmio_uart_tx_if.slave     bus,
  output logic              tx,
  output logic              irq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Bus decode
  logic       hit;
  logic       wr;
  logic       rd;
  logic [1:0] reg_idx;

  assign hit     = bus.ce && (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign wr      = hit && bus.we;
  assign rd      = hit && !bus.we;
  assign reg_idx = bus.addr[3:2];
  assign bus.sel = hit;

  // Control/status registers
  logic [15:0] div_q;
  logic        irq_en;
  logic        ovf;

  // FIFO
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic [AW:0] count;
  logic        empty;
  logic        full;
  logic [7:0]  head;
  logic        push_req;
  logic        push_ok;
  logic        pop;
  logic        ovf_set;

  // Transmitter
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tx_q;
  logic        busy;
  logic        bit_done;
  logic [15:0] reload;
`ifdef MMIO_UART_TX_PARITY_EN
  logic        par_q;
`endif

  assign count    = wptr - rptr;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign head     = mem[rptr[AW-1:0]];
  assign busy     = (state != S_IDLE);
  assign bit_done = (cnt == 16'd0);
  // A divider of zero behaves as one cycle per bit.
  assign reload   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;

  // The FSM takes the head byte on leaving IDLE or at the end of a STOP bit.
  assign pop      = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_done));
  assign push_req = wr && (reg_idx == 2'd0);
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  // FIFO pointers: one extra wrap bit each so full and empty are distinguishable.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
    end
  end

  // FIFO storage write.
  // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr[AW-1:0]] <= bus.data_i[7:0];
  end

  // Software-visible registers; an overflow in the same cycle as a clear wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q  <= DIV_RESET;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr && (reg_idx == 2'd2)) div_q  <= bus.data_i[15:0];
      if (wr && (reg_idx == 2'd3)) irq_en <= bus.data_i[0];
      if (ovf_set)                                      ovf <= 1'b1;
      else if (wr && (reg_idx == 2'd1) && bus.data_i[3]) ovf <= 1'b0;
    end
  end

  // Transmit FSM: each state holds one bit for max(DIV,1) cycles; tx is registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      tx_q    <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            state <= S_START;
            shreg <= head;
            cnt   <= reload;
            tx_q  <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q <= ^head;
`endif
          end
        end
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            cnt     <= reload;
            bit_idx <= 3'd0;
            tx_q    <= shreg[0];
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            cnt <= reload;
            if (bit_idx == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state <= S_PARITY;
              tx_q  <= par_q;
`else
              state <= S_STOP;
              tx_q  <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_done) begin
            state <= S_STOP;
            cnt   <= reload;
            tx_q  <= 1'b1;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_done) begin
            if (!empty) begin
              state <= S_START;
              shreg <= head;
              cnt   <= reload;
              tx_q  <= 1'b0;
`ifdef MMIO_UART_TX_PARITY_EN
              par_q <= ^head;
`endif
            end else begin
              state <= S_IDLE;
              tx_q  <= 1'b1;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

  assign tx  = tx_q;
  assign irq = irq_en && empty && !busy;

  // Combinational read mux; zero whenever the window is not being read.
  // NOTE: assigning a default first keeps this block free of inferred latches.
  always_comb begin
    bus.data_o = 32'd0;
    if (rd) begin
      case (reg_idx)
        2'd1:    bus.data_o = {18'd0, 6'(count), 4'd0, ovf, busy, empty, full};
        2'd2:    bus.data_o = {16'd0, div_q};
        2'd3:    bus.data_o = {31'd0, irq_en};
        default: bus.data_o = 32'd0;
      endcase
    end
  end

  // Address byte-lane bits and upper write-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = &{1'b0, bus.addr[1:0], bus.data_i[31:16]};

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: register access, frame timing, FIFO
// overflow, interrupt, divider change, mid-frame reset and randomized bursts.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE  = 32'h0000_1000;
  localparam int          DEPTH = 8;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam logic [3:0] A_TX   = 4'h0;
  localparam logic [3:0] A_ST   = 4'h4;
  localparam logic [3:0] A_DIV  = 4'h8;
  localparam logic [3:0] A_CTRL = 4'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] exp_q[$];

  mmio_uart_tx_if bus_if ();

  mmio_uart_tx #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(DEPTH),
    .DIV_RESET (16'd16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus_if),
    .tx (tx),
    .irq(irq)
  );

  always #5 clk = ~clk;

  // Frame bit i of a byte: start, 8 data LSB first, optional even parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return b[i-1];
`ifdef MMIO_UART_TX_PARITY_EN
    if (i == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic bus_write(input logic [3:0] off, input logic [31:0] d);
    @(negedge clk);
    bus_if.ce     = 1'b1;
    bus_if.we     = 1'b1;
    bus_if.addr   = BASE | {28'h0, off};
    bus_if.data_i = d;
    @(posedge clk);
    #1;
    bus_if.ce = 1'b0;
    bus_if.we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] off, output logic [31:0] d);
    @(negedge clk);
    bus_if.ce   = 1'b1;
    bus_if.we   = 1'b0;
    bus_if.addr = BASE | {28'h0, off};
    #1;
    d = bus_if.data_o;
    bus_if.ce = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b0;
    bus_if.ce = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Entered 1ns after the edge that starts the frame; leaves 1ns after the frame's last edge.
  task automatic check_frame(input logic [7:0] b, input int d_first, input int d_rest,
                             input string name);
    int len;
    for (int i = 0; i < NBITS; i++) begin
      len = (i == 0) ? d_first : d_rest;
      for (int k = 0; k < len; k++) begin
        checks++;
        if (tx !== frame_bit(b, i) || irq !== 1'b0) begin
          errors++;
          $display("FAIL %s byte %h bit %0d cycle %0d: tx=%b irq=%b, expected tx=%b irq=0",
                   name, b, i, k, tx, irq, frame_bit(b, i));
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL reset_out: tx=%b irq=%b, expected tx=1 irq=0", tx, irq);
    end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL reset_status: got %h expected 00000002", rd); end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || irq !== 1'b0) begin
      errors++; $display("FAIL post_reset_out: tx=%b irq=%b, expected tx=1 irq=0", tx, irq);
    end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL post_reset_status: got %h expected 00000002", rd); end
    bus_read(A_DIV, rd);
    checks++;
    if (rd !== 32'd16) begin errors++; $display("FAIL reset_div: got %h expected 00000010", rd); end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'd0) begin errors++; $display("FAIL reset_ctrl: got %h expected 00000000", rd); end
    // Address decode: just outside the window, inside, and strobe low.
    @(negedge clk);
    bus_if.ce = 1'b1; bus_if.we = 1'b0; bus_if.addr = BASE + 32'h10;
    #1;
    checks++;
    if (bus_if.sel !== 1'b0 || bus_if.data_o !== 32'd0) begin
      errors++; $display("FAIL sel_outside: sel=%b data_o=%h, expected 0/0", bus_if.sel, bus_if.data_o);
    end
    bus_if.addr = BASE + 32'h8;
    #1;
    checks++;
    if (bus_if.sel !== 1'b1 || bus_if.data_o !== 32'd16) begin
      errors++; $display("FAIL sel_inside: sel=%b data_o=%h, expected 1/00000010", bus_if.sel, bus_if.data_o);
    end
    bus_if.ce = 1'b0;
    #1;
    checks++;
    if (bus_if.sel !== 1'b0 || bus_if.data_o !== 32'd0) begin
      errors++; $display("FAIL sel_no_ce: sel=%b data_o=%h, expected 0/0", bus_if.sel, bus_if.data_o);
    end
  endtask

  task automatic test_frame_a5();
    logic [31:0] rd;
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'hA5);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL a5_push_edge: tx=%b expected 1", tx); end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h100) begin errors++; $display("FAIL a5_status_after_push: got %h expected 00000100", rd); end
    @(posedge clk);
    #1;
    check_frame(8'hA5, 4, 4, "a5_frame");
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL a5_after_frame: tx=%b expected 1", tx); end
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL a5_status_idle: got %h expected 00000002", rd); end
  endtask

  task automatic test_byte_07();
    logic [31:0] rd;
    bus_write(A_DIV, 32'd3);
    bus_write(A_TX, 32'h07);
    @(posedge clk);
    #1;
    check_frame(8'h07, 3, 3, "byte07_frame");
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2 || tx !== 1'b1) begin
      errors++; $display("FAIL byte07_idle: status=%h tx=%b expected 00000002/1", rd, tx);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [31:0] want;
    bus_write(A_DIV, 32'd16);
    for (int i = 0; i < 9; i++) bus_write(A_TX, 32'h30 + i);
    // One byte left for the shift register, eight waiting: full, busy, no overflow.
    want = (32'd8 << 8) | 32'h4 | 32'h1;
    bus_read(A_ST, rd);
    checks++;
    if (rd !== want) begin errors++; $display("FAIL ovf_nine_pushes: got %h expected %h", rd, want); end
    bus_write(A_TX, 32'h55);
    bus_read(A_ST, rd);
    checks++;
    if (rd !== (want | 32'h8)) begin
      errors++; $display("FAIL ovf_set: got %h expected %h", rd, want | 32'h8);
    end
    bus_write(A_ST, 32'h8);
    bus_read(A_ST, rd);
    checks++;
    if (rd !== want) begin errors++; $display("FAIL ovf_clear: got %h expected %h", rd, want); end
    do_reset();
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL ovf_reset_status: got %h expected 00000002", rd); end
  endtask

  task automatic test_irq();
    logic [7:0] b1;
    logic [7:0] b2;
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    bus_write(A_DIV, 32'd2);
    bus_write(A_CTRL, 32'd1);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_idle_enabled: irq=%b expected 1", irq); end
    bus_write(A_TX, {24'd0, b1});
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_push: irq=%b expected 0", irq); end
    @(posedge clk);
    #1;
    check_frame(b1, 2, 2, "irq_frame1");
    checks++;
    if (irq !== 1'b1 || tx !== 1'b1) begin
      errors++; $display("FAIL irq_after_stop: irq=%b tx=%b expected 1/1", irq, tx);
    end
    bus_write(A_TX, {24'd0, b2});
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_second_push: irq=%b expected 0", irq); end
    @(posedge clk);
    #1;
    check_frame(b2, 2, 2, "irq_frame2");
    bus_write(A_CTRL, 32'd0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_disabled: irq=%b expected 0", irq); end
  endtask

  task automatic test_div_change();
    logic [7:0]  b;
    logic [31:0] rd;
    b = 8'($urandom);
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, {24'd0, b});
    fork
      begin
        @(negedge clk);
        bus_write(A_DIV, 32'd8);
      end
      begin
        @(posedge clk);
        #1;
        check_frame(b, 4, 8, "div_change_frame");
      end
    join
    bus_read(A_DIV, rd);
    checks++;
    if (rd !== 32'd8) begin errors++; $display("FAIL div_readback: got %h expected 00000008", rd); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    int          lows;
    bus_write(A_DIV, 32'd4);
    bus_write(A_TX, 32'h00);
    bus_write(A_TX, 32'hFF);
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midframe_data_bit: tx=%b expected 0", tx); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midframe_async_tx: tx=%b expected 1", tx); end
    @(negedge clk);
    rst = 1'b1;
    bus_read(A_ST, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL midframe_status: got %h expected 00000002", rd); end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) lows++;
    end
    checks++;
    if (lows !== 0) begin errors++; $display("FAIL midframe_residual: %0d low cycles, expected 0", lows); end
  endtask

  task automatic test_back_to_back_random();
    logic [7:0]  bytes [3];
    logic [7:0]  e;
    logic [31:0] rd;
    int          d;
    int          deff;
    int          m;
    for (int it = 0; it < 6; it++) begin
      d    = $urandom_range(0, 3);
      deff = (d == 0) ? 1 : d;
      m    = $urandom_range(1, 3);
      for (int j = 0; j < 3; j++) bytes[j] = 8'($urandom);
      bus_write(A_DIV, 32'(d));
      fork
        begin
          for (int j = 0; j < m; j++) begin
            exp_q.push_back(bytes[j]);
            bus_write(A_TX, {24'd0, bytes[j]});
          end
        end
        begin
          @(posedge clk);
          @(posedge clk);
          #1;
          for (int j = 0; j < m; j++) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL random_model_empty: iteration %0d frame %0d", it, j);
            end else begin
              e = exp_q.pop_front();
              check_frame(e, deff, deff, "random_frame");
            end
          end
        end
      join
      bus_read(A_ST, rd);
      checks++;
      if (rd !== 32'h2 || tx !== 1'b1) begin
        errors++; $display("FAIL random_idle: iteration %0d status=%h tx=%b expected 00000002/1", it, rd, tx);
      end
    end
  endtask

  initial begin
    bus_if.ce     = 1'b0;
    bus_if.we     = 1'b0;
    bus_if.addr   = 32'd0;
    bus_if.data_i = 32'd0;
    test_reset();
    test_frame_a5();
    test_byte_07();
    test_overflow();
    test_irq();
    test_div_change();
    test_reset_mid_frame();
    test_back_to_back_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
